// File: rtl/score_pkg.sv
// Shared constants and types for the score button arbiter and its consumer.
package score_pkg;
  localparam int NUM_BTN_MAX             = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_SCORE_INC       = 1;
  localparam int ADDI_SCORE_ADDR         = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;
endpackage

// File: rtl/score_button_arbiter_if.sv
// Score event valid/ready port: the arbiter is the master, the score logic the slave.
interface score_button_arbiter_if #(
  parameter int PLY_W = 2
);
  logic             evt_valid;
  logic             evt_ready;
  logic [PLY_W-1:0] evt_player;
  logic [31:0]      evt_value;

  modport master (output evt_valid, evt_player, evt_value, input evt_ready);
  modport slave  (input evt_valid, evt_player, evt_value, output evt_ready);
endinterface

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser followed by a stable-count debouncer.
module button_debounce
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic light_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          light_q, light_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the output.
  always_comb begin
    light_d = light_q;
    cnt_d   = '0;
    if (sync2_q != light_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) light_d = ~light_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      light_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      light_q <= light_d;
      cnt_q   <= cnt_d;
    end
  end

  assign light_o = light_q;
endmodule

// File: rtl/score_button_arbiter.sv
// Debounced player buttons -> per-player pending requests -> round-robin valid/ready score events.
module score_button_arbiter
  import score_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SCORE_INC       = DEFAULT_SCORE_INC,
  parameter int PLY_W           = $clog2(NUM_BTN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BTN-1:0]     button_i,
  output logic [NUM_BTN-1:0]     light_o,
  output logic [NUM_BTN-1:0]     pending_o,
  output logic [15:0]            drop_count_o,
  score_button_arbiter_if.master evt
);
  logic [NUM_BTN-1:0] light, light_q, press, accept, drop;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [15:0]        drop_count_q, drop_count_d;
  logic [16:0]        drop_sum;
  int                 n_drop;

  arb_state_e         state_q, state_d;
  logic [PLY_W-1:0]   evt_player_q, evt_player_d;
  logic [PLY_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]        evt_value_q;
  logic [PLY_W-1:0]   pick_idx, idx;
  logic               pick_found, handshake;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .button_i (button_i[g]),
      .light_o  (light[g])
    );
  end

  assign handshake = (state_q == OFFER) && evt.evt_ready;
  assign press     = light & ~light_q;

  // A press landing on the cycle its own request is accepted becomes the next request.
  always_comb begin
    accept = '0;
    n_drop = 0;
    for (int i = 0; i < NUM_BTN; i++)
      accept[i] = handshake && (evt_player_q == PLY_W'(i));
    pending_d = press | (pending_q & ~accept);
    drop      = press & pending_q & ~accept;
    for (int i = 0; i < NUM_BTN; i++)
      n_drop += int'(drop[i]);
    drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      light_q      <= '0;
      pending_q    <= '0;
      drop_count_q <= '0;
    end else begin
      light_q      <= light;
      pending_q    <= pending_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Round-robin: first pending bit strictly after the last grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = PLY_W'((int'(last_grant_q) + k) % NUM_BTN);
      if (!pick_found && pending_q[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      evt_player_q <= '0;
      last_grant_q <= PLY_W'(NUM_BTN - 1);
      evt_value_q  <= 32'(SCORE_INC);
    end else begin
      state_q      <= state_d;
      evt_player_q <= evt_player_d;
      last_grant_q <= last_grant_d;
      evt_value_q  <= 32'(SCORE_INC);
    end
  end

  always_comb begin
    state_d      = state_q;
    evt_player_d = evt_player_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: if (pick_found) begin
        state_d      = OFFER;
        evt_player_d = pick_idx;
      end
      OFFER: if (evt.evt_ready) begin
        state_d      = IDLE;
        last_grant_d = evt_player_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt.evt_valid  = (state_q == OFFER);
    evt.evt_player = evt_player_q;
    evt.evt_value  = evt_value_q;
  end

  assign light_o      = light;
  assign pending_o    = pending_q;
  assign drop_count_o = drop_count_q;
endmodule

// File: tb/tb_score_button_arbiter.sv
// Directed bench for score_button_arbiter with NUM_BTN=4, DEBOUNCE_CYCLES=4.
module tb_score_button_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  button, light, pending;
  logic [15:0] drop_count;

  score_button_arbiter_if #(.PLY_W(2)) evt ();

  score_button_arbiter #(
    .NUM_BTN(4), .DEBOUNCE_CYCLES(4), .SCORE_INC(1), .PLY_W(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_i     (button),
    .light_o      (light),
    .pending_o    (pending),
    .drop_count_o (drop_count),
    .evt          (evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic [3:0] light;
    logic [3:0] pend;
    logic       vld;
    logic [1:0] ply;
  } vec_t;

  vec_t vecs[$];
  int   grants[$];
  int   vcyc[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: note any handshake about to complete, then sample 1 time unit after the edge.
  task automatic step();
    if (evt.evt_valid && evt.evt_ready) grants.push_back(int'(evt.evt_player));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_light(input int b, input logic v, input string nm);
    int n = 0;
    while (light[b] !== v && n < 40) begin step(); n++; end
    chk(nm, 32'(light[b]), 32'(v));
  endtask

  task automatic wait_pend(input int b, input logic v, input string nm);
    int n = 0;
    while (pending[b] !== v && n < 40) begin step(); n++; end
    chk(nm, 32'(pending[b]), 32'(v));
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (evt.evt_valid !== 1'b1 && n < 40) begin step(); n++; end
    chk(nm, 32'(evt.evt_valid), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    grants.delete();
  endtask

  initial begin
    int bad;
    vec_t v;
    reset = 1'b1;
    button = '0;
    evt.evt_ready = 1'b0;

    // Clean press of player 0 held 12 cycles then released, then a bouncing player 1.
    for (int k = 1; k <= 20; k++) begin
      v.btn = (k <= 12) ? 4'b0001 : 4'b0000;
      v.rdy = 1'b1;
      v.light = (k >= 6 && k <= 17) ? 4'b0001 : 4'b0000;
      v.pend = (k == 7 || k == 8) ? 4'b0001 : 4'b0000;
      v.vld = (k == 8);
      v.ply = 2'd0;
      vecs.push_back(v);
    end
    for (int k = 1; k <= 24; k++) begin
      v.btn = (k <= 16 && ((k - 1) / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      v.rdy = 1'b1;
      v.light = '0;
      v.pend = '0;
      v.vld = 1'b0;
      v.ply = 2'd0;
      vecs.push_back(v);
    end

    step(); step();
    reset = 1'b0;
    chk("reset light", 32'(light), 0);
    chk("reset pending", 32'(pending), 0);
    chk("reset valid", 32'(evt.evt_valid), 0);
    chk("reset player", 32'(evt.evt_player), 0);
    chk("reset drop", 32'(drop_count), 0);
    grants.delete();

    for (int r = 0; r < vecs.size(); r++) begin
      button = vecs[r].btn;
      evt.evt_ready = vecs[r].rdy;
      step();
      chk($sformatf("vec%0d light", r), 32'(light), 32'(vecs[r].light));
      chk($sformatf("vec%0d pending", r), 32'(pending), 32'(vecs[r].pend));
      chk($sformatf("vec%0d valid", r), 32'(evt.evt_valid), 32'(vecs[r].vld));
      if (vecs[r].vld) begin
        chk($sformatf("vec%0d player", r), 32'(evt.evt_player), 32'(vecs[r].ply));
        chk($sformatf("vec%0d value", r), evt.evt_value, 32'd1);
      end
    end
    chk("clean press grants", 32'(grants.size()), 1);
    chk("bounce drop", 32'(drop_count), 0);

    // Simultaneous presses: grants 0,1,2,3 with valid every other cycle.
    do_reset();
    evt.evt_ready = 1'b1;
    button = 4'b1111;
    vcyc.delete();
    for (int c = 1; c <= 20; c++) begin
      step();
      if (evt.evt_valid) vcyc.push_back(c);
    end
    chk("simul grant count", 32'(grants.size()), 4);
    chk("simul valid count", 32'(vcyc.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("simul grant%0d", i), 32'((i < grants.size()) ? grants[i] : -1), 32'(i));
      chk($sformatf("simul vcyc%0d", i), 32'((i < vcyc.size()) ? vcyc[i] : -1), 32'(8 + 2 * i));
    end
    chk("simul pending", 32'(pending), 0);
    button = '0;
    repeat (10) step();

    // Backpressure on player 2 with a second press during the stall.
    do_reset();
    evt.evt_ready = 1'b0;
    button = 4'b0100;
    wait_valid("stall offer");
    chk("stall player", 32'(evt.evt_player), 2);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0)  button = 4'b0000;
      if (c == 12) button = 4'b0100;
      step();
      if (evt.evt_valid !== 1'b1 || evt.evt_player !== 2'd2 || evt.evt_value !== 32'd1) bad++;
    end
    chk("stall stable", 32'(bad), 0);
    chk("stall drop", 32'(drop_count), 1);
    chk("stall pending", 32'(pending), 32'h4);
    evt.evt_ready = 1'b1;
    step();
    chk("stall release valid", 32'(evt.evt_valid), 0);
    chk("stall release pending", 32'(pending), 0);
    bad = 0;
    repeat (4) begin step(); if (evt.evt_valid !== 1'b0) bad++; end
    chk("stall no extra", 32'(bad), 0);
    chk("stall grants", 32'(grants.size()), 1);
    chk("stall grant player", 32'((grants.size() > 0) ? grants[0] : -1), 2);

    // Reset mid-offer: last_grant was 2, so player 3 is offered first.
    button = 4'b0000;
    wait_light(2, 1'b0, "rst release light");
    evt.evt_ready = 1'b0;
    button = 4'b1010;
    wait_valid("rst offer");
    chk("rst pre player", 32'(evt.evt_player), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst valid", 32'(evt.evt_valid), 0);
    chk("rst pending", 32'(pending), 0);
    chk("rst light", 32'(light), 0);
    chk("rst drop", 32'(drop_count), 0);
    wait_valid("rst re-offer");
    chk("rst first player", 32'(evt.evt_player), 1);
    evt.evt_ready = 1'b1;
    repeat (6) step();
    button = '0;
    repeat (10) step();

    // Fairness: player 0 re-presses exactly as its grant lands; player 3 must go next.
    do_reset();
    evt.evt_ready = 1'b0;
    button = 4'b1001;
    wait_valid("fair offer0");
    chk("fair player0", 32'(evt.evt_player), 0);
    button = 4'b1000;
    wait_light(0, 1'b0, "fair light0 low");
    button = 4'b1001;
    wait_light(0, 1'b1, "fair light0 high");
    grants.delete();
    evt.evt_ready = 1'b1;
    step();
    chk("fair same-cycle pending", 32'(pending), 32'h9);
    chk("fair same-cycle drop", 32'(drop_count), 0);
    chk("fair same-cycle valid", 32'(evt.evt_valid), 0);
    step();
    chk("fair next player", 32'(evt.evt_player), 3);
    step();
    step();
    chk("fair back to 0", 32'(evt.evt_player), 0);
    evt.evt_ready = 1'b0;
    button = 4'b0001;
    wait_light(3, 1'b0, "fair light3 low");
    button = 4'b1001;
    wait_pend(3, 1'b1, "fair pend3");
    evt.evt_ready = 1'b1;
    step(); step(); step();
    chk("fair grant count", 32'(grants.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fair grant%0d", i), 32'((i < grants.size()) ? grants[i] : -1),
          32'((i % 2 == 0) ? 0 : 3));
    chk("fair pending", 32'(pending), 0);
    chk("fair drop", 32'(drop_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
